// File: rtl/add_pipe.sv
// Pipelined ripple adder/subtractor: one K-bit carry chunk per stage, valid/ready flow control.
// Operand chunks travel with the transaction so stage j only ever sees the carry registered by stage j-1.
module add_pipe #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         co,
    output logic         ov
);

    localparam int S = N / K;

    logic         advance;
    logic         v_q  [S];
    logic         c_q  [S];
    logic [N-1:0] a_q  [S];
    logic [N-1:0] b_q  [S];
    logic [N-1:0] s_q  [S];
    logic         ov_q;

    logic         v_in [S];
    logic         c_in [S];
    logic [N-1:0] a_in [S];
    logic [N-1:0] b_in [S];
    logic [N-1:0] s_in [S];
    logic [N-1:0] s_nx [S];
    logic         c_nx [S];
    logic [K:0]   sum  [S];
    logic         ov_nx;
    logic         unused_bits;

    always_comb begin
        advance = !v_q[S-1] || out_ready;

        v_in[0] = in_valid;
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        c_in[0] = sub ? 1'b1 : ci;
        s_in[0] = '0;
        for (int j = 1; j < S; j++) begin
            v_in[j] = v_q[j-1];
            a_in[j] = a_q[j-1];
            b_in[j] = b_q[j-1];
            c_in[j] = c_q[j-1];
            s_in[j] = s_q[j-1];
        end

        for (int j = 0; j < S; j++) begin
            sum[j] = {1'b0, a_in[j][j*K +: K]} + {1'b0, b_in[j][j*K +: K]}
                   + {{K{1'b0}}, c_in[j]};
            s_nx[j] = s_in[j];
            s_nx[j][j*K +: K] = sum[j][K-1:0];
            c_nx[j] = sum[j][K];
        end

        // carry into the MSB recovered from the MSB's own sum bit
        ov_nx = a_in[S-1][N-1] ^ b_in[S-1][N-1] ^ sum[S-1][K-1] ^ sum[S-1][K];

        unused_bits = 1'b0;
        for (int j = 0; j < S; j++) begin
            unused_bits = unused_bits ^ (^{a_q[j], b_q[j]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < S; j++) begin
                v_q[j] <= 1'b0;
                c_q[j] <= 1'b0;
                a_q[j] <= '0;
                b_q[j] <= '0;
                s_q[j] <= '0;
            end
            ov_q <= 1'b0;
        end else if (advance) begin
            for (int j = 0; j < S - 1; j++) begin
                v_q[j] <= v_in[j];
                c_q[j] <= c_nx[j];
                a_q[j] <= a_in[j];
                b_q[j] <= b_in[j];
                s_q[j] <= s_nx[j];
            end
            // last stage doubles as the output register: zeroed when empty
            v_q[S-1] <= v_in[S-1];
            a_q[S-1] <= a_in[S-1];
            b_q[S-1] <= b_in[S-1];
            s_q[S-1] <= v_in[S-1] ? s_nx[S-1] : '0;
            c_q[S-1] <= v_in[S-1] && c_nx[S-1];
            ov_q     <= v_in[S-1] && ov_nx;
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[S-1];
    assign s         = s_q[S-1];
    assign co        = c_q[S-1];
    assign ov        = ov_q;

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: three configurations (16/4, 16/16, 12/3) checked every cycle against a queue model.
module tb_add_pipe;

    logic        clk;
    logic        rst;
    logic        iv   [3];
    logic        ci   [3];
    logic        sb   [3];
    logic        ordy [3];
    logic [15:0] a    [3];
    logic [15:0] b    [3];
    logic        ir   [3];
    logic        ovld [3];
    logic        cout [3];
    logic        ovf  [3];
    logic [15:0] s0, s1;
    logic [11:0] s2;

    int checks   = 0;
    int failures = 0;
    int got [3];
    logic [17:0] q [3][$];

    add_pipe #(.N(16), .K(4)) u_p16_4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a[0]), .b(b[0]), .ci(ci[0]), .sub(sb[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .s(s0), .co(cout[0]), .ov(ovf[0]));

    add_pipe #(.N(16), .K(16)) u_p16_16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a[1]), .b(b[1]), .ci(ci[1]), .sub(sb[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .s(s1), .co(cout[1]), .ov(ovf[1]));

    add_pipe #(.N(12), .K(3)) u_p12_3 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a[2][11:0]), .b(b[2][11:0]), .ci(ci[2]), .sub(sb[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .s(s2), .co(cout[2]), .ov(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(int i);
        return (i == 2) ? 12 : 16;
    endfunction

    function automatic logic [15:0] s_of(int i);
        case (i)
            0:       return s0;
            1:       return s1;
            default: return {4'h0, s2};
        endcase
    endfunction

    // {ov, co, s}: plain integer arithmetic, overflow from operand/result signs
    function automatic logic [17:0] model(logic [15:0] x, logic [15:0] y, logic c, logic su, int n);
        logic [31:0] m, yy, full;
        logic [15:0] r;
        logic        cy, ovr;
        m    = (32'd1 << n) - 32'd1;
        yy   = su ? (~{16'h0, y}) & m : {16'h0, y};
        full = {16'h0, x} + yy + {31'h0, (su ? 1'b1 : c)};
        r    = full[15:0] & m[15:0];
        cy   = full[n];
        ovr  = (x[n-1] == yy[n-1]) && (r[n-1] != x[n-1]);
        return {ovr, cy, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                q[i].delete();
            end else begin
                chk($sformatf("in_ready[%0d]", i), {31'h0, ir[i]}, {31'h0, !ovld[i] || ordy[i]});
                if (ovld[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_result[%0d]", i), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("result[%0d]", i), {14'h0, ovf[i], cout[i], s_of(i)},
                            {14'h0, q[i][0]});
                        if (ordy[i]) begin
                            void'(q[i].pop_front());
                            got[i]++;
                        end
                    end
                end else begin
                    chk($sformatf("idle_zero[%0d]", i), {14'h0, ovf[i], cout[i], s_of(i)}, 32'd0);
                end
                if (iv[i] && ir[i])
                    q[i].push_back(model(a[i], b[i], ci[i], sb[i], width_of(i)));
            end
        end
    end

    // single directed transaction on the 16/4 instance; pins latency and value
    task automatic send1(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic su, input logic [17:0] exp);
        int lat;
        a[0] = x; b[0] = y; ci[0] = c; sb[0] = su; iv[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ovld[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 4);
        chk({name, "_value"}, {14'h0, ovf[0], cout[0], s0}, {14'h0, exp});
        @(posedge clk);
        #1;
    endtask

    logic [15:0] bp_a [6];
    logic [15:0] bp_b [6];

    initial begin
        int sent, base;
        bit acc;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ci[i] = 1'b0; sb[i] = 1'b0; ordy[i] = 1'b1;
            a[i] = '0; b[i] = '0; got[i] = 0;
        end

        chk("model_wrap12", {14'h0, model(16'h0FFF, 16'h0001, 1'b0, 1'b0, 12)}, 32'h1_0000);
        chk("model_sub12", {14'h0, model(16'h0800, 16'h0001, 1'b0, 1'b1, 12)}, 32'h3_07FF);
        chk("model_ci16", {14'h0, model(16'h1234, 16'h1111, 1'b1, 1'b0, 16)}, 32'h0_2346);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'h0, ovld[0]}, 32'd0);
        chk("reset_s", {16'h0, s0}, 32'd0);
        chk("reset_in_ready", {31'h0, ir[0]}, 32'd1);
        @(posedge clk);
        #1;

        send1("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h1_0000);
        send1("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0_FFFE);
        send1("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 18'h3_7FFF);
        send1("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h2_8000);

        // six back-to-back, three-cycle stall mid-stream
        for (int k = 0; k < 6; k++) begin
            bp_a[k] = 16'h1000 * 16'(k + 1) + 16'h0011;
            bp_b[k] = 16'h0F0F + 16'(k);
        end
        base = got[0];
        sent = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ordy[0] = !(cyc >= 5 && cyc < 8);
            iv[0] = (sent < 6);
            if (sent < 6) begin
                a[0] = bp_a[sent]; b[0] = bp_b[sent]; ci[0] = sent[0]; sb[0] = sent[1];
            end
            #1 acc = iv[0] && ir[0];
            if (cyc == 6) chk("stall_in_ready", {31'h0, ir[0]}, 32'd0);
            @(posedge clk);
            if (acc) sent++;
            #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        chk("bp_count", got[0] - base, 6);

        // reset with two transactions in flight
        a[0] = 16'hAAAA; b[0] = 16'h1111; sb[0] = 1'b0; ci[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 a[0] = 16'h5555;
        @(posedge clk);
        #1 iv[0] = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_valid", {31'h0, ovld[0]}, 32'd0);
        base = got[0];
        repeat (8) @(posedge clk);
        #1;
        chk("rst_flush_none", got[0] - base, 0);
        send1("post_rst", 16'h0102, 16'h0304, 1'b1, 1'b0, 18'h0_0407);

        // random regression on all three configurations
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i]   = ($urandom_range(0, 3) != 0);
                ordy[i] = ($urandom_range(0, 3) != 0);
                a[i]    = 16'($urandom) & ((width_of(i) == 12) ? 16'h0FFF : 16'hFFFF);
                b[i]    = 16'($urandom) & ((width_of(i) == 12) ? 16'h0FFF : 16'hFFFF);
                ci[i]   = 1'($urandom);
                sb[i]   = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (30) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("drain[%0d]", i), q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter N, default 16, operand width in bits.
REQ-002 Parameter K, default 4, chunk width per pipeline stage; N SHALL be an integer multiple of K; S = N/K stages.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block accepts the operands this cycle.
REQ-007 a, b  input  N each  operands, unsigned or two's complement.
REQ-008 ci  input  1  carry in; ignored when sub=1.
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 s  output  N  sum or difference.
REQ-013 co  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-014 ov  output  1  two's-complement overflow flag.

Function
REQ-015 Arithmetic: sub=0 -> {co,s} = a + b + ci; sub=1 -> {co,s} = a + ~b + 1, with ci ignored.
REQ-016 ov SHALL equal carry into bit N-1 XOR co.
REQ-017 Carry chain split into S chunks of K bits; stage j adds chunk j only, using the carry registered from stage j-1 (stage 0 uses the effective carry in).
REQ-018 No combinational carry path SHALL span more than K bits.
REQ-019 Input skew registers SHALL delay chunk j of a/~b by j cycles; output deskew registers SHALL align all chunks so s, co and ov of one transaction appear together.
REQ-020 Each stage SHALL carry a valid bit.
REQ-021 Global advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-022 On advance, every stage shifts by one and stage 0 loads in_valid && in_ready.
REQ-023 Without advance, all pipeline state SHALL hold.
REQ-024 Transfer occurs only on a cycle where valid && ready are both high.
REQ-025 Latency: a transaction accepted on cycle t SHALL present out_valid on cycle t+S when no stall occurs.
REQ-026 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-027 Order SHALL be preserved; no transaction shall be lost or duplicated under any out_ready pattern.
REQ-028 While out_valid=1 and out_ready=0, s/co/ov SHALL remain stable.
REQ-029 With S=1 (K=N), the block SHALL behave as a single registered adder with latency 1.
REQ-030 Data registers of invalid stages are don't-care, but s/co/ov SHALL read 0 whenever out_valid=0.

Reset
REQ-031 rst=1 at a clock edge SHALL clear all stage valid bits and zero the output registers.
REQ-032 The cycle after reset: out_valid=0, s=0, co=0, ov=0, in_ready=1.
REQ-033 Transactions in flight when rst asserts SHALL be discarded and never emerge.
REQ-034 in_valid is ignored during a reset cycle.

Verification (N=16, K=4, S=4)
REQ-035 Reset: drive rst for 2 cycles -> out_valid=0, s=0x0000, in_ready=1.
REQ-036 Add wrap: a=0xFFFF, b=0x0001, ci=0, sub=0, accepted at t -> at t+4, out_valid=1, s=0x0000, co=1, ov=0.
REQ-037 Subtract:
- 0x0005-0x0007 -> s=0xFFFE, co=0, ov=0.
- 0x8000-0x0001 -> s=0x7FFF, co=1, ov=1.
- 0x7FFF+0x0001 with ci=0 -> s=0x8000, co=0, ov=1.
REQ-038 Backpressure: send 6 back-to-back transactions; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 6 results in order with no duplicates.
REQ-039 Reset mid-operation: assert rst with 2 transactions in flight -> out_valid=0 the next cycle and neither result ever appears; a new transaction afterwards has latency 4.
REQ-040 Random regression: 10k random a/b/ci/sub with random out_ready, checked against a reference model, for (N,K) = (16,4), (16,16) and (12,3).
